// File: rtl/vip_matrix_ctrl.sv
// vip_matrix_ctrl: raster controller feeding a Bayer matrix generator, with row blanking and a drain row per frame
module vip_matrix_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int HBLANK = 5,
  parameter logic [1:0] BAYER_PAT = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        i_ready,
  output logic        o_vsync,
  output logic        o_href,
  output logic        o_clken,
  output logic [7:0]  o_data,
  output logic [11:0] o_col,
  output logic [11:0] o_row,
  output logic [1:0]  o_phase,
  output logic        o_busy,
  output logic        o_frame_done
);
  typedef enum logic [2:0] {stIdle, stActive, stHblank, stFlush, stDone} stateT;
  localparam logic [11:0] lastCol = 12'(IMG_W - 1);
  localparam logic [11:0] lastRow = 12'(IMG_H - 1);
  localparam logic [11:0] flushRow = 12'(IMG_H);
  localparam logic [7:0] lastBlank = 8'(HBLANK - 1);
  stateT state, nextState;
  logic [11:0] col, row;
  logic [7:0] blankCnt;
  logic acc, colEnd, rowEnd, blankEnd, flushBeat;
  assign i_ready = !rst && (state == stIdle || state == stActive);
  assign acc = i_valid && i_ready;
  assign colEnd = col == lastCol;
  assign rowEnd = row == lastRow;
  assign blankEnd = blankCnt == lastBlank;
  assign flushBeat = state == stFlush;
  always_comb begin
    nextState = state;
    case (state)
      stIdle, stActive: begin
        if (acc) nextState = stActive;
        if (acc && colEnd) nextState = (HBLANK > 0) ? stHblank : (rowEnd ? stFlush : stActive);
      end
      stHblank: if (blankEnd) nextState = (row == flushRow) ? stFlush : stActive;
      stFlush: if (colEnd) nextState = stDone;
      default: nextState = stIdle;
    endcase
  end
  // row == IMG_H marks the drain row, both for the blank exit and for the flush beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= stIdle;
      col <= '0;
      row <= '0;
      blankCnt <= '0;
      o_vsync <= 1'b0;
      o_href <= 1'b0;
      o_clken <= 1'b0;
      o_data <= '0;
      o_col <= '0;
      o_row <= '0;
      o_phase <= '0;
      o_busy <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state <= nextState;
      blankCnt <= (state == stHblank) ? blankCnt + 8'd1 : 8'd0;
      if (acc || flushBeat) col <= colEnd ? 12'd0 : col + 12'd1;
      if (acc && colEnd) row <= rowEnd ? flushRow : row + 12'd1;
      if (flushBeat && colEnd) row <= 12'd0;
      o_clken <= acc || flushBeat;
      o_data <= acc ? i_data : 8'd0;
      o_col <= col;
      o_row <= row;
      o_phase <= {row[0], col[0]} ^ BAYER_PAT;
      o_href <= acc || flushBeat || (state == stActive && o_href);
      o_vsync <= acc || state == stActive || state == stHblank || flushBeat;
      o_busy <= nextState != stIdle || state == stDone;
      o_frame_done <= state == stDone;
    end
  end
endmodule

// File: tb/tb_vip_matrix_ctrl.sv
// tb_vip_matrix_ctrl: directed checks of the matrix controller on a 4x3 frame
module tb_vip_matrix_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [7:0] din = '0;
  logic rdy[3], clken[3], href[3], vsync[3], busy[3], fdone[3];
  logic [7:0] dout[3];
  logic [11:0] ocol[3], orow[3];
  logic [1:0] oph[3];
  localparam int hbOf[3] = '{2, 0, 2};
  localparam logic [1:0] patOf[3] = '{2'b00, 2'b00, 2'b01};
  for (genvar g = 0; g < 3; g++) begin : gDut
    vip_matrix_ctrl #(.IMG_W(4), .IMG_H(3), .HBLANK(hbOf[g]), .BAYER_PAT(patOf[g])) dut (
      .clk(clk), .rst(rst), .i_valid(vld), .i_data(din), .i_ready(rdy[g]),
      .o_vsync(vsync[g]), .o_href(href[g]), .o_clken(clken[g]), .o_data(dout[g]),
      .o_col(ocol[g]), .o_row(orow[g]), .o_phase(oph[g]), .o_busy(busy[g]),
      .o_frame_done(fdone[g])
    );
  end
  int nCmp = 0, nBad = 0, sel = 0;
  int nBeats, nDone, firstBeat, doneCyc, gapClk, gapHrefLow, hrefLowMid, rdyLowFeed, vsCyc;
  logic [7:0] bD[64];
  logic [11:0] bC[64], bR[64];
  logic [1:0] bP[64];
  typedef struct {
    logic v; logic [7:0] d; logic rdy, ck; logic [7:0] od; logic [11:0] c, r; logic hr, vs, fd, bz;
  } vecT;
  vecT vec[25];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [39:0] pack(input logic r, ck, hr, vs, fd, bz, input logic [7:0] d,
                                       input logic [11:0] c, rw, input logic [1:0] p);
    return {r, ck, hr, vs, fd, bz, ck ? d : 8'd0, ck ? c : 12'd0, ck ? rw : 12'd0, ck ? p : 2'd0};
  endfunction
  function automatic logic [39:0] obs(input int s);
    return pack(rdy[s], clken[s], href[s], vsync[s], fdone[s], busy[s], dout[s], ocol[s], orow[s], oph[s]);
  endfunction
  function automatic vecT mk(input int v, d, r, ck, od, c, rw, hr, vs, fd, bz);
    return '{v[0], 8'(d), r[0], ck[0], 8'(od), 12'(c), 12'(rw), hr[0], vs[0], fd[0], bz[0]};
  endfunction
  task automatic doReset();
    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic runStream(input int dropAt, input int dropLen);
    int pix, accN, dropLeft;
    logic [11:0] ec, er;
    logic [7:0] ed;
    int firstBadIdx;
    nBeats = 0; nDone = 0; firstBeat = -1; doneCyc = -1; gapClk = 0; gapHrefLow = 0;
    hrefLowMid = 0; rdyLowFeed = 0; vsCyc = 0;
    pix = 1; accN = 0; dropLeft = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (clken[sel]) begin
        if (nBeats < 64) begin
          bD[nBeats] = dout[sel]; bC[nBeats] = ocol[sel]; bR[nBeats] = orow[sel]; bP[nBeats] = oph[sel];
        end
        if (nBeats == 0) firstBeat = cyc;
        nBeats++;
      end
      if (dropAt > 0 && nBeats == dropAt && !clken[sel]) begin
        gapClk++;
        if (!href[sel]) gapHrefLow++;
      end
      if (!clken[sel] && !href[sel] && nBeats > 0 && nBeats < 16) hrefLowMid++;
      if (vsync[sel]) vsCyc++;
      if (!rdy[sel] && pix <= 12) rdyLowFeed++;
      if (fdone[sel]) begin
        nDone++;
        doneCyc = cyc;
        vld = 1'b0;
        break;
      end
      if (dropLeft > 0) begin
        vld = 1'b0;
        dropLeft--;
      end else vld = pix <= 12;
      din = (pix <= 12) ? 8'(pix) : 8'd0;
      if (vld && rdy[sel]) begin
        pix++;
        accN++;
        if (accN == dropAt) dropLeft = dropLen;
      end
      @(negedge clk);
    end
    chk("frame done count", 64'(nDone), 64'd1);
    chk("beat count", 64'(nBeats), 64'd16);
    firstBadIdx = -1;
    for (int k = 0; k < 16 && k < nBeats; k++) begin
      ed = (k < 12) ? 8'(k + 1) : 8'd0;
      ec = 12'(k % 4);
      er = 12'(k / 4);
      if (firstBadIdx < 0 && {bD[k], bC[k], bR[k], bP[k]} !== {ed, ec, er, {er[0], ec[0]} ^ patOf[sel]})
        firstBadIdx = k;
    end
    chk("beat sequence first bad index", 64'(firstBadIdx), 64'(-1));
  endtask
  initial begin
    vec[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[1]  = mk(1, 2, 1, 1, 1, 0, 0, 1, 1, 0, 1);
    vec[2]  = mk(1, 3, 1, 1, 2, 1, 0, 1, 1, 0, 1);
    vec[3]  = mk(1, 4, 1, 1, 3, 2, 0, 1, 1, 0, 1);
    vec[4]  = mk(1, 5, 0, 1, 4, 3, 0, 1, 1, 0, 1);
    vec[5]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[6]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[7]  = mk(1, 6, 1, 1, 5, 0, 1, 1, 1, 0, 1);
    vec[8]  = mk(1, 7, 1, 1, 6, 1, 1, 1, 1, 0, 1);
    vec[9]  = mk(1, 8, 1, 1, 7, 2, 1, 1, 1, 0, 1);
    vec[10] = mk(1, 9, 0, 1, 8, 3, 1, 1, 1, 0, 1);
    vec[11] = mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[12] = mk(1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[13] = mk(1, 10, 1, 1, 9, 0, 2, 1, 1, 0, 1);
    vec[14] = mk(1, 11, 1, 1, 10, 1, 2, 1, 1, 0, 1);
    vec[15] = mk(1, 12, 1, 1, 11, 2, 2, 1, 1, 0, 1);
    vec[16] = mk(1, 13, 0, 1, 12, 3, 2, 1, 1, 0, 1);
    vec[17] = mk(1, 13, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[18] = mk(1, 13, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec[19] = mk(1, 13, 0, 1, 0, 0, 3, 1, 1, 0, 1);
    vec[20] = mk(1, 13, 0, 1, 0, 1, 3, 1, 1, 0, 1);
    vec[21] = mk(1, 13, 0, 1, 0, 2, 3, 1, 1, 0, 1);
    vec[22] = mk(1, 13, 0, 1, 0, 3, 3, 1, 1, 0, 1);
    vec[23] = mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    vec[24] = mk(0, 0, 1, 1, 13, 0, 0, 1, 1, 0, 1);
    repeat (2) @(negedge clk);
    chk("outputs during reset", 64'(obs(0)), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", 64'(rdy[0]), 64'd1);
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("continuous vector %0d", i), 64'(obs(0)),
          64'(pack(vec[i].rdy, vec[i].ck, vec[i].hr, vec[i].vs, vec[i].fd, vec[i].bz, vec[i].od,
                   vec[i].c, vec[i].r, {vec[i].r[0], vec[i].c[0]})));
      vld = vec[i].v;
      din = vec[i].d;
      @(negedge clk);
    end
    sel = 0;
    doReset();
    runStream(6, 3);
    chk("stall clken-low cycles", 64'(gapClk), 64'd3);
    chk("stall href-low cycles", 64'(gapHrefLow), 64'd0);
    chk("beat after stall col/row", {bC[6], bR[6]}, {12'd2, 12'd1});
    chk("stall vsync cycles", 64'(vsCyc), 64'd25);
    sel = 1;
    doReset();
    runStream(0, 0);
    chk("hblank0 href gaps", 64'(hrefLowMid), 64'd0);
    chk("hblank0 ready gaps", 64'(rdyLowFeed), 64'd0);
    chk("hblank0 first beat to done", 64'(doneCyc - firstBeat), 64'd16);
    chk("hblank0 vsync cycles", 64'(vsCyc), 64'd16);
    sel = 2;
    doReset();
    runStream(0, 0);
    chk("bayer01 phases", {bP[0], bP[1], bP[4], bP[5]}, {2'b01, 2'b00, 2'b11, 2'b10});
    sel = 0;
    doReset();
    begin
      int pix = 1;
      for (int cyc = 0; cyc < 20 && pix <= 4; cyc++) begin
        vld = 1'b1;
        din = 8'(pix);
        if (rdy[0]) pix++;
        @(negedge clk);
      end
      vld = 1'b0;
      chk("in hblank before reset", {rdy[0], busy[0]}, {1'b0, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      chk("outputs after mid-frame reset", 64'(obs(0)), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready after mid-frame reset", {rdy[0], busy[0], fdone[0]}, {1'b1, 1'b0, 1'b0});
      runStream(0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/vip_matrix_ctrl.md
VIP_MATRIX_CTRL -- requirements
Module: vip_matrix_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IMG_W, 640, active pixels per row, 2..4095.
- IMG_H, 480, active rows per frame, 2..4095.
- HBLANK, 5, forced idle cycles after each row, 0..255.
- BAYER_PAT, 2'b00, phase of pixel (0,0): 00=RGGB, 01=GRBG, 10=GBRG, 11=BGGR.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- i_valid, in, 1, source pixel valid.
- i_data, in, 8, source raw Bayer pixel.
- i_ready, out, 1, controller accepts pixel this cycle.
- o_vsync, out, 1, frame envelope to the matrix generator.
- o_href, out, 1, row envelope to the matrix generator.
- o_clken, out, 1, pixel strobe to the matrix generator.
- o_data, out, 8, pixel to the matrix generator.
- o_col, out, 12, column index of the o_data pixel.
- o_row, out, 12, row index of the o_data pixel.
- o_phase, out, 2, Bayer phase of the o_data pixel.
- o_busy, out, 1, frame in progress.
- o_frame_done, out, 1, one-cycle end-of-frame pulse.

Function
REQ-003 FSM states SHALL be IDLE, ACTIVE, HBLANK, FLUSH and DONE.
REQ-004 IDLE SHALL drive i_ready=1; the first accepted beat (i_valid&i_ready) SHALL move the FSM to ACTIVE and is pixel (0,0).
REQ-005 A beat SHALL be accepted only when i_valid&i_ready; i_ready SHALL be 1 in IDLE and ACTIVE and 0 in HBLANK, FLUSH and DONE.
REQ-006 Outputs SHALL be registered, one cycle after acceptance:
- o_clken=1, o_data=i_data.
- o_col and o_row = indices of the accepted beat.
- o_phase = {row[0],col[0]} XOR BAYER_PAT.
REQ-007 In ACTIVE, i_valid low SHALL give o_clken=0 with o_href held at 1 and counters held; no pixel SHALL be dropped or duplicated.
REQ-008 Acceptance of column IMG_W-1 SHALL wrap the column to 0 and advance as follows:
- If rows remain: go to HBLANK with the row incremented.
- If it was row IMG_H-1: go to FLUSH.
REQ-009 HBLANK SHALL last exactly HBLANK cycles with o_href=0 and o_clken=0, then return to ACTIVE; HBLANK=0 SHALL go straight back to ACTIVE with no idle cycle.
REQ-010 o_href SHALL rise with the first o_clken of a row and fall the cycle after that row's last o_clken.
REQ-011 FLUSH SHALL emit, on consecutive cycles, one extra row of IMG_W beats with o_clken=1, o_data=0, o_row=IMG_H and o_col 0..IMG_W-1, so the matrix generator drains its last row.
REQ-012 Before FLUSH, the FSM SHALL first spend HBLANK blank cycles; FLUSH beats SHALL begin after that blank.
REQ-013 o_vsync SHALL rise with the first o_clken of the frame and fall the cycle after the last FLUSH beat.
REQ-014 DONE SHALL last one cycle with o_frame_done=1 and all envelopes 0, then return to IDLE.
REQ-015 o_busy SHALL be 1 in every state except IDLE.
REQ-016 Counters SHALL be 12 bits, compare against IMG_W-1 and IMG_H-1 exactly, and never exceed IMG_W-1 or IMG_H.

Reset
REQ-017 While rst=1 the FSM SHALL go to IDLE, clear counters, and drive all outputs to 0 except i_ready.
REQ-018 i_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.
REQ-019 Reset asserted mid-frame SHALL abandon the frame: no FLUSH and no o_frame_done; the next accepted beat is pixel (0,0).

Verification (IMG_W=4, IMG_H=3, HBLANK=2, BAYER_PAT=00 unless noted)
REQ-020 Continuous i_valid with data 1..12:
- o_clken beats carry 1..4, 5..8, 9..12, then four zeros with o_row=3.
- Each row is followed by 2 cycles of o_href=0 and i_ready=0.
- o_frame_done pulses once; o_vsync stays high for exactly the 22 cycles from the first o_clken to the last FLUSH beat.
REQ-021 i_valid dropped for 3 cycles after pixel (1,1):
- o_href stays 1 and o_clken is 0 for those 3 cycles.
- The next beat carries o_col=2, o_row=1; the total beat count stays 16.
REQ-022 HBLANK=0:
- Rows are back-to-back with no o_href gap and no i_ready gap.
- The frame completes in 16 clken cycles plus DONE.
REQ-023 BAYER_PAT=01:
- o_phase for pixels (0,0),(0,1),(1,0),(1,1) SHALL be 01,00,11,10.
REQ-024 rst pulsed during HBLANK after row 0:
- All outputs go to 0 and no o_frame_done is produced.
- A new stream of 12 pixels completes a full frame starting at o_row=0, o_col=0.
REQ-025 i_valid held high across HBLANK, FLUSH and DONE:
- No beat is accepted while i_ready=0.
- Data presented during those cycles SHALL reappear unchanged on the next accepted beat (source holds its data while i_ready=0).
